axi_lite_slave_bridge: RTL and testbench
========================================

AXI_LITE_SLAVE_BRIDGE -- requirements
Module: axi_lite_slave_bridge

Interface
REQ-001 C_S_AXI_ADDR_WIDTH, 32, address width of slave and user request ports.
REQ-002 C_S_AXI_DATA_WIDTH, 32, data width; strobe width is C_S_AXI_DATA_WIDTH/8.
REQ-003 TIMEOUT, 256, cycles to wait for a user ack before returning SLVERR; 0 disables the timeout.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 ACLK  in  1  sole clock, rising edge.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 S_AXI_AWADDR  in  ADDR_W  write address.
REQ-008 S_AXI_AWVALID  in  1  write address valid.
REQ-009 S_AXI_AWREADY  out  1  write address ready.
REQ-010 S_AXI_WDATA  in  DATA_W  write data.
REQ-011 S_AXI_WSTRB  in  DATA_W/8  write byte strobes.
REQ-012 S_AXI_WVALID  in  1  write data valid.
REQ-013 S_AXI_WREADY  out  1  write data ready.
REQ-014 S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
REQ-015 S_AXI_BVALID  out  1  write response valid.
REQ-016 S_AXI_BREADY  in  1  write response ready.
REQ-017 S_AXI_ARADDR  in  ADDR_W  read address.
REQ-018 S_AXI_ARVALID  in  1  read address valid.
REQ-019 S_AXI_ARREADY  out  1  read address ready.
REQ-020 S_AXI_RDATA  out  DATA_W  read data.
REQ-021 S_AXI_RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
REQ-022 S_AXI_RVALID  out  1  read data valid.
REQ-023 S_AXI_RREADY  in  1  read data ready.
REQ-024 wreq_valid  out  1  user write request valid.
REQ-025 wreq_addr  out  ADDR_W  user write address.
REQ-026 wreq_data  out  DATA_W  user write data.
REQ-027 wreq_strb  out  DATA_W/8  user write strobes.
REQ-028 wreq_ready  in  1  user accepts the write request.
REQ-029 wack_valid  in  1  single-cycle user write-complete pulse.
REQ-030 rreq_valid  out  1  user read request valid.
REQ-031 rreq_addr  out  ADDR_W  user read address.
REQ-032 rreq_ready  in  1  user accepts the read request.
REQ-033 rack_valid  in  1  single-cycle user read-complete pulse.
REQ-034 rack_data  in  DATA_W  read data, qualified by rack_valid.

Function
REQ-035 Write FSM SHALL have states W_IDLE, W_REQ, W_WAIT and W_RESP.
- W_IDLE: AWREADY and WREADY are each high only while that channel's holding register is empty.
- AW and W are captured independently, in either order or in the same cycle.
- Once both are held, the FSM moves to W_REQ.
REQ-036 W_REQ: wreq_valid=1 with the held addr/data/strb, all stable until wreq_ready; then go to W_WAIT and clear the timer.
REQ-037 W_WAIT: on wack_valid, go to W_RESP with BRESP=OKAY.
- If TIMEOUT>0 and the timer reaches TIMEOUT-1 with no ack, go to W_RESP with BRESP=SLVERR.
- An ack in that same cycle wins (OKAY).
REQ-038 W_RESP: BVALID=1, held until BREADY; then clear both holding registers and return to W_IDLE.
REQ-039 Read FSM SHALL have states R_IDLE, R_REQ, R_WAIT and R_RESP.
- ARREADY is high only in R_IDLE.
- rreq_valid is held until rreq_ready.
- rack_valid in R_WAIT registers rack_data into RDATA with RRESP=OKAY.
- On timeout, RDATA=0 and RRESP=SLVERR.
- RVALID is held until RREADY.
REQ-040 wack_valid outside W_WAIT and rack_valid outside R_WAIT SHALL be ignored.
REQ-041 Read and write paths SHALL be fully independent and may run concurrently; at most one of each is outstanding.
REQ-042 All outputs SHALL be registered.
REQ-043 Minimum latency SHALL be as follows:
- AW+W handshake at edge N gives wreq_valid at N+1.
- With ready at N+1 and ack at N+2, BVALID rises at N+3.
- The read path has the same timing.
REQ-044 The timer SHALL be $clog2(TIMEOUT+1) bits, saturating, and active only in the *_WAIT states.

Reset
REQ-045 Reset assertion SHALL asynchronously set:
- all FSMs to IDLE;
- all valid and ready outputs, BRESP, RRESP, RDATA, the holding registers and the timers to 0.
REQ-046 In-flight transactions SHALL be dropped without a B or R response, and AWREADY, WREADY and ARREADY SHALL rise on the first edge after deassertion.

Verification
REQ-047 AW(0x10) and W(0xA5A5A5A5, strb F) in the same cycle; wreq_ready at once; ack 1 cycle later -> wreq_addr=0x10, data=0xA5A5A5A5, BRESP=00, BVALID 3 cycles after the handshake.
REQ-048 W leads AW by 4 cycles, strb=0x3 -> a single wreq with strb=0x3; WREADY low after W is captured until BREADY.
REQ-049 TIMEOUT=8 with no rack -> RVALID with RRESP=10 and RDATA=0 after 8 R_WAIT cycles; a late rack is ignored.
REQ-050 Read and write concurrent; BREADY held low 5 cycles -> BVALID/BRESP stable; the read completes unaffected; a stray wack in W_RESP is ignored.
REQ-051 ARESETN pulsed low during W_WAIT -> outputs 0 immediately; no BVALID; next write completes OKAY.

Source files
------------

// File: rtl/axi_lite_slave_bridge.sv
// AXI4-Lite slave to simple user request/acknowledge bridge.
// The write and read paths are independent FSMs. Each path allows one
// outstanding transaction and has an optional acknowledge timeout that
// answers with SLVERR. Every output is driven directly from a register.
module axi_lite_slave_bridge #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT            = 256
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    // AXI write address / data / response
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // AXI read address / data
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // user write side
    output logic                            wreq_valid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   wreq_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   wreq_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] wreq_strb,
    input  logic                            wreq_ready,
    input  logic                            wack_valid,
    // user read side
    output logic                            rreq_valid,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   rreq_addr,
    input  logic                            rreq_ready,
    input  logic                            rack_valid,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   rack_data
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    // A zero-width timer is impossible, so keep one bit when the timeout is disabled.
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic              TMO_EN   = (TIMEOUT > 0);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TMR_W-1:0]  TMR_MAX  = '1;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} rstate_t;

    // ---------------- write path state ----------------
    wstate_t                     r_wstate, w_wstate_next;
    logic                        r_aw_full, w_aw_full_next;
    logic                        r_w_full, w_w_full_next;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr, w_awaddr_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata, w_wdata_next;
    logic [STRB_W-1:0]           r_wstrb, w_wstrb_next;
    logic                        r_awready, w_awready_next;
    logic                        r_wready, w_wready_next;
    logic                        r_wreq_valid, w_wreq_valid_next;
    logic                        r_bvalid, w_bvalid_next;
    logic [1:0]                  r_bresp, w_bresp_next;
    logic [TMR_W-1:0]            r_wtimer, w_wtimer_next;

    // ---------------- read path state ----------------
    rstate_t                     r_rstate, w_rstate_next;
    logic                        r_ar_full, w_ar_full_next;
    logic [C_S_AXI_ADDR_WIDTH-1:0] r_araddr, w_araddr_next;
    logic                        r_arready, w_arready_next;
    logic                        r_rreq_valid, w_rreq_valid_next;
    logic                        r_rvalid, w_rvalid_next;
    logic [1:0]                  r_rresp, w_rresp_next;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_next;
    logic [TMR_W-1:0]            r_rtimer, w_rtimer_next;

    // Write FSM next state: capture AW and W independently, issue, wait, respond.
    always_comb begin
        w_wstate_next = r_wstate;
        w_aw_full_next = r_aw_full;
        w_w_full_next  = r_w_full;
        w_awaddr_next  = r_awaddr;
        w_wdata_next   = r_wdata;
        w_wstrb_next   = r_wstrb;
        w_bvalid_next  = r_bvalid;
        w_bresp_next   = r_bresp;
        w_wtimer_next  = '0;
        case (r_wstate)
            W_IDLE: begin
                if (S_AXI_AWVALID && r_awready) begin
                    w_aw_full_next = 1'b1;
                    w_awaddr_next  = S_AXI_AWADDR;
                end
                if (S_AXI_WVALID && r_wready) begin
                    w_w_full_next = 1'b1;
                    w_wdata_next  = S_AXI_WDATA;
                    w_wstrb_next  = S_AXI_WSTRB;
                end
                if (r_aw_full && r_w_full) begin
                    w_wstate_next = W_REQ;
                end
            end
            W_REQ: begin
                if (wreq_ready) begin
                    w_wstate_next = W_WAIT;
                end
            end
            W_WAIT: begin
                w_wtimer_next = (r_wtimer == TMR_MAX) ? r_wtimer : r_wtimer + TMR_W'(1);
                // An acknowledge in the final timeout cycle still counts as success.
                if (wack_valid) begin
                    w_wstate_next = W_RESP;
                    w_bvalid_next = 1'b1;
                    w_bresp_next  = RESP_OKAY;
                end else if (TMO_EN && (r_wtimer == TMR_LAST)) begin
                    w_wstate_next = W_RESP;
                    w_bvalid_next = 1'b1;
                    w_bresp_next  = RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_wstate_next  = W_IDLE;
                    w_bvalid_next  = 1'b0;
                    w_aw_full_next = 1'b0;
                    w_w_full_next  = 1'b0;
                    w_awaddr_next  = '0;
                    w_wdata_next   = '0;
                    w_wstrb_next   = '0;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
        // Ready/valid outputs are decoded from the next state so they are registered.
        w_awready_next    = (w_wstate_next == W_IDLE) && !w_aw_full_next;
        w_wready_next     = (w_wstate_next == W_IDLE) && !w_w_full_next;
        w_wreq_valid_next = (w_wstate_next == W_REQ);
    end

    // Write path registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate     <= W_IDLE;
            r_aw_full    <= 1'b0;
            r_w_full     <= 1'b0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_wreq_valid <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= 2'b00;
            r_wtimer     <= '0;
        end else begin
            r_wstate     <= w_wstate_next;
            r_aw_full    <= w_aw_full_next;
            r_w_full     <= w_w_full_next;
            r_awaddr     <= w_awaddr_next;
            r_wdata      <= w_wdata_next;
            r_wstrb      <= w_wstrb_next;
            r_awready    <= w_awready_next;
            r_wready     <= w_wready_next;
            r_wreq_valid <= w_wreq_valid_next;
            r_bvalid     <= w_bvalid_next;
            r_bresp      <= w_bresp_next;
            r_wtimer     <= w_wtimer_next;
        end
    end

    // Read FSM next state: capture AR, issue, wait for data or timeout, respond.
    always_comb begin
        w_rstate_next  = r_rstate;
        w_ar_full_next = r_ar_full;
        w_araddr_next  = r_araddr;
        w_rvalid_next  = r_rvalid;
        w_rresp_next   = r_rresp;
        w_rdata_next   = r_rdata;
        w_rtimer_next  = '0;
        case (r_rstate)
            R_IDLE: begin
                if (S_AXI_ARVALID && r_arready) begin
                    w_ar_full_next = 1'b1;
                    w_araddr_next  = S_AXI_ARADDR;
                end
                // One cycle of holding keeps read timing identical to the write path.
                if (r_ar_full) begin
                    w_rstate_next = R_REQ;
                end
            end
            R_REQ: begin
                if (rreq_ready) begin
                    w_rstate_next = R_WAIT;
                end
            end
            R_WAIT: begin
                w_rtimer_next = (r_rtimer == TMR_MAX) ? r_rtimer : r_rtimer + TMR_W'(1);
                if (rack_valid) begin
                    w_rstate_next = R_RESP;
                    w_rvalid_next = 1'b1;
                    w_rresp_next  = RESP_OKAY;
                    w_rdata_next  = rack_data;
                end else if (TMO_EN && (r_rtimer == TMR_LAST)) begin
                    w_rstate_next = R_RESP;
                    w_rvalid_next = 1'b1;
                    w_rresp_next  = RESP_SLVERR;
                    w_rdata_next  = '0;
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    w_rstate_next  = R_IDLE;
                    w_rvalid_next  = 1'b0;
                    w_ar_full_next = 1'b0;
                    w_araddr_next  = '0;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
        w_arready_next    = (w_rstate_next == R_IDLE) && !w_ar_full_next;
        w_rreq_valid_next = (w_rstate_next == R_REQ);
    end

    // Read path registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate     <= R_IDLE;
            r_ar_full    <= 1'b0;
            r_araddr     <= '0;
            r_arready    <= 1'b0;
            r_rreq_valid <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rresp      <= 2'b00;
            r_rdata      <= '0;
            r_rtimer     <= '0;
        end else begin
            r_rstate     <= w_rstate_next;
            r_ar_full    <= w_ar_full_next;
            r_araddr     <= w_araddr_next;
            r_arready    <= w_arready_next;
            r_rreq_valid <= w_rreq_valid_next;
            r_rvalid     <= w_rvalid_next;
            r_rresp      <= w_rresp_next;
            r_rdata      <= w_rdata_next;
            r_rtimer     <= w_rtimer_next;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign wreq_valid    = r_wreq_valid;
    assign wreq_addr     = r_awaddr;
    assign wreq_data     = r_wdata;
    assign wreq_strb     = r_wstrb;
    assign rreq_valid    = r_rreq_valid;
    assign rreq_addr     = r_araddr;

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
// Directed bench for axi_lite_slave_bridge with an 8-cycle acknowledge timeout.
module tb_axi_lite_slave_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            ACLK = 1'b0;
    logic            ARESETN = 1'b0;
    logic [AW-1:0]   S_AXI_AWADDR = '0;
    logic            S_AXI_AWVALID = 1'b0;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA = '0;
    logic [DW/8-1:0] S_AXI_WSTRB = '0;
    logic            S_AXI_WVALID = 1'b0;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY = 1'b0;
    logic [AW-1:0]   S_AXI_ARADDR = '0;
    logic            S_AXI_ARVALID = 1'b0;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY = 1'b0;
    logic            wreq_valid;
    logic [AW-1:0]   wreq_addr;
    logic [DW-1:0]   wreq_data;
    logic [DW/8-1:0] wreq_strb;
    logic            wreq_ready = 1'b0;
    logic            wack_valid = 1'b0;
    logic            rreq_valid;
    logic [AW-1:0]   rreq_addr;
    logic            rreq_ready = 1'b0;
    logic            rack_valid = 1'b0;
    logic [DW-1:0]   rack_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_slave_bridge #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .TIMEOUT(TMO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .wreq_valid(wreq_valid), .wreq_addr(wreq_addr), .wreq_data(wreq_data),
        .wreq_strb(wreq_strb), .wreq_ready(wreq_ready), .wack_valid(wack_valid),
        .rreq_valid(rreq_valid), .rreq_addr(rreq_addr), .rreq_ready(rreq_ready),
        .rack_valid(rack_valid), .rack_data(rack_data)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;      // write data, or data returned on rack
        logic [3:0]  strb;
        int          ack_dly;   // wait cycles before ack; >= TMO means no ack (timeout)
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_write(input vec_t v, input string tag);
        chk({tag, ".awready_idle"}, 32'(S_AXI_AWREADY), 1);
        chk({tag, ".wready_idle"}, 32'(S_AXI_WREADY), 1);
        S_AXI_AWADDR = v.addr; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = v.data;  S_AXI_WSTRB = v.strb; S_AXI_WVALID = 1'b1;
        tick();                                  // handshake edge N
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk({tag, ".awready_held"}, 32'(S_AXI_AWREADY), 0);
        chk({tag, ".wreq_early"}, 32'(wreq_valid), 0);
        tick();                                  // N+1
        chk({tag, ".wreq_valid"}, 32'(wreq_valid), 1);
        chk({tag, ".wreq_addr"}, wreq_addr, v.addr);
        chk({tag, ".wreq_data"}, wreq_data, v.data);
        chk({tag, ".wreq_strb"}, 32'(wreq_strb), 32'(v.strb));
        wreq_ready = 1'b1;
        tick();                                  // N+2: W_WAIT
        wreq_ready = 1'b0;
        chk({tag, ".wreq_drop"}, 32'(wreq_valid), 0);
        if (v.ack_dly < TMO) begin
            repeat (v.ack_dly) tick();
            chk({tag, ".bvalid_pre"}, 32'(S_AXI_BVALID), 0);
            wack_valid = 1'b1;
            tick();
            wack_valid = 1'b0;
        end else begin
            repeat (TMO - 1) tick();
            chk({tag, ".bvalid_pre_tmo"}, 32'(S_AXI_BVALID), 0);
            tick();
        end
        $display("write %s addr=0x%08h data=0x%08h strb=0x%h bvalid=%0d bresp=%02b", tag, v.addr, v.data, v.strb, S_AXI_BVALID, S_AXI_BRESP);
        chk({tag, ".bvalid"}, 32'(S_AXI_BVALID), 1);
        chk({tag, ".bresp"}, 32'(S_AXI_BRESP), 32'(v.exp_resp));
        if (v.ack_dly >= TMO) begin
            wack_valid = 1'b1;                   // late ack must be ignored
            tick();
            wack_valid = 1'b0;
            chk({tag, ".bresp_late_ack"}, 32'(S_AXI_BRESP), 32'(v.exp_resp));
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk({tag, ".bvalid_done"}, 32'(S_AXI_BVALID), 0);
        chk({tag, ".awready_back"}, 32'(S_AXI_AWREADY), 1);
        chk({tag, ".wready_back"}, 32'(S_AXI_WREADY), 1);
    endtask

    task automatic do_read(input vec_t v, input string tag);
        chk({tag, ".arready_idle"}, 32'(S_AXI_ARREADY), 1);
        S_AXI_ARADDR = v.addr; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        chk({tag, ".arready_held"}, 32'(S_AXI_ARREADY), 0);
        chk({tag, ".rreq_early"}, 32'(rreq_valid), 0);
        tick();
        chk({tag, ".rreq_valid"}, 32'(rreq_valid), 1);
        chk({tag, ".rreq_addr"}, rreq_addr, v.addr);
        rreq_ready = 1'b1;
        tick();
        rreq_ready = 1'b0;
        chk({tag, ".rreq_drop"}, 32'(rreq_valid), 0);
        if (v.ack_dly < TMO) begin
            repeat (v.ack_dly) tick();
            chk({tag, ".rvalid_pre"}, 32'(S_AXI_RVALID), 0);
            rack_valid = 1'b1; rack_data = v.data;
            tick();
            rack_valid = 1'b0; rack_data = '0;
        end else begin
            repeat (TMO - 1) tick();
            chk({tag, ".rvalid_pre_tmo"}, 32'(S_AXI_RVALID), 0);
            tick();
        end
        $display("read  %s addr=0x%08h rvalid=%0d rresp=%02b rdata=0x%08h", tag, v.addr, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA);
        chk({tag, ".rvalid"}, 32'(S_AXI_RVALID), 1);
        chk({tag, ".rresp"}, 32'(S_AXI_RRESP), 32'(v.exp_resp));
        chk({tag, ".rdata"}, S_AXI_RDATA, v.exp_rdata);
        if (v.ack_dly >= TMO) begin
            rack_valid = 1'b1; rack_data = v.data;   // late data must be ignored
            tick();
            rack_valid = 1'b0; rack_data = '0;
            chk({tag, ".rdata_late_ack"}, S_AXI_RDATA, v.exp_rdata);
            chk({tag, ".rresp_late_ack"}, 32'(S_AXI_RRESP), 32'(v.exp_resp));
        end
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        chk({tag, ".rvalid_done"}, 32'(S_AXI_RVALID), 0);
        chk({tag, ".arready_back"}, 32'(S_AXI_ARREADY), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0,  2'b00, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'h5, 3,  2'b00, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0030, 32'h0F0F_0F0F, 4'hC, 7,  2'b00, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0034, 32'h5555_AAAA, 4'h1, 99, 2'b10, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'hCAFE_BABE, 4'h0, 0,  2'b00, 32'hCAFE_BABE};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'hDEAD_BEEF, 4'h0, 7,  2'b00, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 32'h0000_0048, 32'h1111_2222, 4'h0, 99, 2'b10, 32'h0};
        vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h0, 2,  2'b00, 32'hFFFF_FFFF};

        // Reset state
        tick(); tick();
        chk("rst.awready", 32'(S_AXI_AWREADY), 0);
        chk("rst.arready", 32'(S_AXI_ARREADY), 0);
        chk("rst.bvalid", 32'(S_AXI_BVALID), 0);
        chk("rst.rvalid", 32'(S_AXI_RVALID), 0);
        chk("rst.wreq_valid", 32'(wreq_valid), 0);
        chk("rst.rdata", S_AXI_RDATA, 0);
        ARESETN = 1'b1;
        chk("rst.awready_before_edge", 32'(S_AXI_AWREADY), 0);
        tick();
        chk("rst.awready_first_edge", 32'(S_AXI_AWREADY), 1);
        chk("rst.wready_first_edge", 32'(S_AXI_WREADY), 1);
        chk("rst.arready_first_edge", 32'(S_AXI_ARREADY), 1);

        // Table-driven transactions
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i], $sformatf("vec%0d", i));
            else               do_read(vecs[i], $sformatf("vec%0d", i));
            tick();
        end

        // W leads AW by four cycles with partial strobes
        S_AXI_WDATA = 32'h0000_BEEF; S_AXI_WSTRB = 4'h3; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("wlead.wready_low", 32'(S_AXI_WREADY), 0);
        chk("wlead.awready_high", 32'(S_AXI_AWREADY), 1);
        repeat (3) begin
            tick();
            chk("wlead.no_wreq", 32'(wreq_valid), 0);
        end
        S_AXI_AWADDR = 32'h0000_0050; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("wlead.wreq_early", 32'(wreq_valid), 0);
        tick();
        chk("wlead.wreq_valid", 32'(wreq_valid), 1);
        chk("wlead.wreq_addr", wreq_addr, 32'h0000_0050);
        chk("wlead.wreq_data", wreq_data, 32'h0000_BEEF);
        chk("wlead.wreq_strb", 32'(wreq_strb), 32'h3);
        wreq_ready = 1'b1;
        tick();
        wreq_ready = 1'b0;
        wack_valid = 1'b1;
        tick();
        wack_valid = 1'b0;
        chk("wlead.bvalid", 32'(S_AXI_BVALID), 1);
        chk("wlead.wready_resp", 32'(S_AXI_WREADY), 0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        $display("seq   wlead bvalid=%0d wready=%0d", S_AXI_BVALID, S_AXI_WREADY);
        chk("wlead.wready_back", 32'(S_AXI_WREADY), 1);
        tick();

        // Concurrent read and write; write times out, B stalled five cycles
        S_AXI_AWADDR = 32'h0000_0060; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h7777_8888; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h0000_0070; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        tick();
        chk("conc.wreq_valid", 32'(wreq_valid), 1);
        chk("conc.rreq_valid", 32'(rreq_valid), 1);
        wreq_ready = 1'b1; rreq_ready = 1'b1;
        tick();
        wreq_ready = 1'b0; rreq_ready = 1'b0;
        rack_valid = 1'b1; rack_data = 32'h0BAD_F00D;
        tick();
        rack_valid = 1'b0; rack_data = '0;
        chk("conc.rvalid", 32'(S_AXI_RVALID), 1);
        chk("conc.rdata", S_AXI_RDATA, 32'h0BAD_F00D);
        chk("conc.rresp", 32'(S_AXI_RRESP), 0);
        chk("conc.bvalid_wait", 32'(S_AXI_BVALID), 0);
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        chk("conc.rvalid_done", 32'(S_AXI_RVALID), 0);
        chk("conc.arready_back", 32'(S_AXI_ARREADY), 1);
        repeat (5) tick();
        chk("conc.bvalid_pre_tmo", 32'(S_AXI_BVALID), 0);
        tick();
        chk("conc.bvalid_tmo", 32'(S_AXI_BVALID), 1);
        chk("conc.bresp_tmo", 32'(S_AXI_BRESP), 32'h2);
        for (int i = 0; i < 5; i++) begin
            wack_valid = (i == 0);               // stray ack in W_RESP
            tick();
            wack_valid = 1'b0;
            chk("conc.bvalid_stall", 32'(S_AXI_BVALID), 1);
            chk("conc.bresp_stall", 32'(S_AXI_BRESP), 32'h2);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        $display("seq   conc bvalid=%0d awready=%0d", S_AXI_BVALID, S_AXI_AWREADY);
        chk("conc.bvalid_done", 32'(S_AXI_BVALID), 0);
        chk("conc.awready_back", 32'(S_AXI_AWREADY), 1);
        tick();

        // Reset pulsed during W_WAIT drops the write without a response
        S_AXI_AWADDR = 32'h0000_0080; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h9999_0000; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tick();
        wreq_ready = 1'b1;
        tick();
        wreq_ready = 1'b0;
        tick();
        #1 ARESETN = 1'b0;
        #1;
        chk("arst.awready", 32'(S_AXI_AWREADY), 0);
        chk("arst.wready", 32'(S_AXI_WREADY), 0);
        chk("arst.arready", 32'(S_AXI_ARREADY), 0);
        chk("arst.wreq_addr", wreq_addr, 0);
        chk("arst.bvalid", 32'(S_AXI_BVALID), 0);
        tick();
        ARESETN = 1'b1;
        wack_valid = 1'b1;
        tick();
        wack_valid = 1'b0;
        chk("arst.awready_first_edge", 32'(S_AXI_AWREADY), 1);
        chk("arst.bvalid_after", 32'(S_AXI_BVALID), 0);
        tick();
        $display("seq   arst bvalid=%0d awready=%0d", S_AXI_BVALID, S_AXI_AWREADY);
        chk("arst.bvalid_later", 32'(S_AXI_BVALID), 0);
        do_write(vecs[1], "arst.next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
